// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / result-out valid/ready handshakes of the FIR MAC sequencer.
// The master side is the environment; the sequencer uses the slave side.
interface fir_mac_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// FIR tap sequencer: accepts a sample, runs LENGTH MAC cycles off the
// tap counter's rollBack flag, then presents the accumulated result.
module fir_mac_sequencer #(
  parameter int LENGTH = 100,
  parameter int CNT_W  = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_mac_sequencer_if.slave   io,
  input  logic                 rollBack,
  output logic                 count_enb,
  output logic                 shift_en,
  output logic                 acc_clr,
  output logic                 mac_en,
  output logic                 busy,
  output logic                 seq_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    LAST,
    OUT
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] mac_cnt_q, mac_cnt_d;
  logic             seq_err_q, seq_err_d;
  logic             at_last;

  assign at_last = (mac_cnt_q == LAST_IDX);

  always_comb begin
    state_d   = state_q;
    mac_cnt_d = mac_cnt_q;
    seq_err_d = seq_err_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) state_d = LOAD;
      end
      LOAD: begin
        state_d   = MAC;
        mac_cnt_d = '0;
      end
      MAC: begin
        mac_cnt_d = mac_cnt_q + 1'b1;
        // rollBack must coincide exactly with the shadow count
        if (rollBack && at_last) begin
          state_d = LAST;
        end else if (rollBack || at_last) begin
          state_d   = IDLE;
          seq_err_d = 1'b1;
        end
      end
      LAST: begin
        state_d = OUT;
      end
      OUT: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      mac_cnt_q <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mac_cnt_q <= mac_cnt_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE) & rst;
  assign io.out_valid = (state_q == OUT);
  assign shift_en     = (state_q == LOAD);
  assign acc_clr      = (state_q == LOAD);
  assign count_enb    = (state_q == MAC) | (state_q == LAST);
  assign mac_en       = (state_q == MAC) | (state_q == LAST);
  assign busy         = (state_q != IDLE);
  assign seq_err      = seq_err_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: tap-counter model, directed scenarios,
// randomized samples, and a queue-based result monitor.
module tb_fir_mac_sequencer;
  localparam int L = 100;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rollBack, count_enb, shift_en, acc_clr, mac_en, busy, seq_err;

  fir_mac_sequencer_if bus ();

  fir_mac_sequencer #(.LENGTH(L), .CNT_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (bus),
    .rollBack  (rollBack),
    .count_enb (count_enb),
    .shift_en  (shift_en),
    .acc_clr   (acc_clr),
    .mac_en    (mac_en),
    .busy      (busy),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tap counter environment, with fault injection on rollBack
  int idx = 0;
  int force_at = -1;
  bit missing = 1'b0;
  always @(posedge clk) begin
    if (!count_enb) idx <= 0;
    else idx <= (idx == L - 1) ? 0 : idx + 1;
  end
  assign rollBack = missing ? 1'b0 :
                    (force_at >= 0) ? (idx == force_at) : (idx == L - 2);

  // 0: always ready, 1: random, 2: never ready
  int or_mode = 0;
  always @(posedge clk) begin
    #1;
    case (or_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ($urandom_range(0, 3) != 0);
      default: bus.out_ready = 1'b0;
    endcase
  end

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  bit prev_ov = 1'b0;
  bit prev_or = 1'b0;
  bit prev_err = 1'b0;
  int macs = 0;

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        if (shift_en) macs = 0;
        if (mac_en) macs++;
        if (bus.out_valid && !prev_ov) begin
          if (exp_q.size() == 0) begin
            chk1("unexpected_out_valid", 1'b1, 1'b0);
          end else begin
            chkn("out_latency", cyc, exp_q.pop_front());
            chkn("mac_cycles", macs, L);
          end
        end
        if (prev_ov && !prev_or) chk1("out_hold", bus.out_valid, 1'b1);
        if (prev_ov && prev_or) chk1("idle_after_out", busy, 1'b0);
        if (bus.out_valid) begin
          chk1("out_busy", busy, 1'b1);
          chk1("out_cnt_enb", count_enb, 1'b0);
        end
        if (prev_err) chk1("seq_err_sticky", seq_err, 1'b1);
      end
      prev_ov  = bus.out_valid;
      prev_or  = bus.out_ready;
      prev_err = seq_err;
    end
  endtask

  task automatic at(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
    chkn("schedule", cyc, c);
  endtask

  task automatic send(input bit expect_out, output int t);
    int n;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (!bus.in_ready) chk1("accept_timeout", 1'b0, 1'b1);
    else if (expect_out) exp_q.push_back(t + L + 2);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk1("idle_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t, prev, c, n, r;
    bit fault;
    bus.in_valid = 1'b0;
    fork
      monitor();
    join_none

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chkn("rst_outputs", {count_enb, shift_en, acc_clr, mac_en,
                         bus.out_valid, busy, seq_err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk1("idle_in_ready", bus.in_ready, 1'b1);
    chk1("idle_busy", busy, 1'b0);

    // nominal run
    or_mode = 0;
    send(1'b1, t);
    at(t + 1);
    chk1("load_shift", shift_en, 1'b1);
    chk1("load_clr", acc_clr, 1'b1);
    chk1("load_mac", mac_en, 1'b0);
    at(t + 2);
    chk1("first_mac", mac_en, 1'b1);
    chk1("first_shift", shift_en, 1'b0);
    at(t + L + 1);
    chk1("last_mac", mac_en, 1'b1);
    at(t + L + 2);
    chk1("nom_out_valid", bus.out_valid, 1'b1);
    chk1("nom_mac_off", mac_en, 1'b0);
    at(t + L + 3);
    chk1("nom_in_ready", bus.in_ready, 1'b1);
    chk1("nom_out_off", bus.out_valid, 1'b0);

    // backpressure
    or_mode = 2;
    send(1'b1, t);
    at(t + L + 2);
    chk1("bp_out_valid", bus.out_valid, 1'b1);
    for (int i = 1; i < 20; i++) begin
      at(t + L + 2 + i);
      chk1("bp_hold", bus.out_valid, 1'b1);
      chk1("bp_in_ready", bus.in_ready, 1'b0);
    end
    or_mode = 0;
    at(t + L + 22);
    chk1("bp_release", bus.out_valid, 1'b1);
    at(t + L + 23);
    chk1("bp_idle", busy, 1'b0);
    chk1("bp_in_ready_back", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;

    // back-to-back with in_valid held
    bus.in_valid = 1'b1;
    prev = -1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      @(negedge clk);
      while (!shift_en && n < 300) begin
        @(negedge clk);
        n++;
      end
      c = cyc;
      chk1("b2b_shift_seen", shift_en, 1'b1);
      exp_q.push_back(c + L + 1);
      if (prev >= 0) chkn("b2b_period", c - prev, L + 3);
      prev = c;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_idle();

    // early rollBack at mac_cnt=50
    force_at = 50;
    send(1'b0, t);
    at(t + 52);
    chk1("early_mac", mac_en, 1'b1);
    chk1("early_err_pre", seq_err, 1'b0);
    at(t + 53);
    chk1("early_err", seq_err, 1'b1);
    chk1("early_cnt_enb", count_enb, 1'b0);
    chk1("early_in_ready", bus.in_ready, 1'b1);
    chk1("early_out", bus.out_valid, 1'b0);
    force_at = -1;
    send(1'b1, t);
    wait_idle();
    chk1("early_err_kept", seq_err, 1'b1);

    // missing rollBack
    missing = 1'b1;
    send(1'b0, t);
    at(t + L);
    chk1("miss_mac", mac_en, 1'b1);
    at(t + L + 1);
    chk1("miss_idle", busy, 1'b0);
    chk1("miss_err", seq_err, 1'b1);
    chk1("miss_out", bus.out_valid, 1'b0);
    missing = 1'b0;

    // reset mid-MAC
    send(1'b0, t);
    at(t + 42);
    chk1("mid_mac", mac_en, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk1("rst_low_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chkn("mid_rst_outputs", {count_enb, shift_en, acc_clr, mac_en,
                               bus.out_valid, busy, seq_err, bus.in_ready}, 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    send(1'b1, t);
    wait_idle();
    chk1("post_rst_err", seq_err, 1'b0);

    // randomized samples with faults and random backpressure
    or_mode = 1;
    for (int s = 0; s < 30; s++) begin
      r = $urandom_range(0, 99);
      fault = 1'b1;
      if (r < 15) force_at = $urandom_range(0, L - 3);
      else if (r < 30) missing = 1'b1;
      else fault = 1'b0;
      send(!fault, t);
      wait_idle();
      if (fault) chk1("rand_err", seq_err, 1'b1);
      force_at = -1;
      missing = 1'b0;
      n = $urandom_range(0, 3);
      repeat (n) @(posedge clk);
      #1;
    end
    or_mode = 0;
    repeat (4) @(posedge clk);
    chkn("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
